muldiv_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32M MUL/DIV family, placed in EX alongside the single-cycle ALU.
- Time-multiplexes one ALU instance for 32 iterations of shift-add multiply or restoring divide.
- Holds the pipeline via busy_o and presents a registered result with a one-cycle done_o pulse.

---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/alu.sv | 31 +++
 rtl/muldiv_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multi-cycle
// multiply/divide sequencer and its add/sub engine.
//   funct3_e : RV32M funct3 encodings (MUL..REMU)
//   state_e  : sequencer states
//   ALU_*    : ALU Operation encodings understood by alu
//   ITER     : iterations per multiply/divide
package muldiv_pkg;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam int unsigned ITER = 32;

  // funct3[2] separates the divide group from the multiply group.
  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

endpackage

// File: rtl/alu.sv
// alu: single-cycle EX-stage ALU, reused by muldiv_ctrl as its add/sub engine.
//   operation  : ALU Operation code (see muldiv_pkg ALU_*)
//   src_a      : first operand
//   src_b      : second operand
//   alu_result : combinational result
module alu
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [OPCODE_LENGTH-1:0] operation,
  input  logic [DATA_WIDTH-1:0]    src_a,
  input  logic [DATA_WIDTH-1:0]    src_b,
  output logic [DATA_WIDTH-1:0]    alu_result
);

  always_comb begin
    alu_result = '0;
    case (operation)
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_ADD: alu_result = src_a + src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_SLT: alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle RV32M MUL/DIV sequencer living in EX beside the ALU.
// Runs 32 iterations of shift-add multiply or restoring divide through one
// alu instance, then a sign fix-up cycle and a one-cycle done pulse.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   start_i    : request, accepted only in IDLE and only without flush_i
//   flush_i    : abort any in-flight operation (no done_o, result_o kept)
//   funct3_i   : RV32M funct3 selecting the operation
//   op_a_i     : rs1 value
//   op_b_i     : rs2 value
//   busy_o     : high in CALC, FIXUP and DONE (pipeline stall)
//   done_o     : one-cycle pulse, result_o valid
//   result_o   : registered result, held until the next accepted start
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  state_e                  state, state_n;
  funct3_e                 f3;
  logic                    sa, sb;
  // hi/lo hold {product high, product low} for multiply, {R, Q} for divide.
  logic [DATA_WIDTH-1:0]   hi, lo;
  logic [DATA_WIDTH-1:0]   mb;
  logic [4:0]              count;

  // start decode
  funct3_e                 f3_in;
  logic                    accept;
  logic                    sa_in, sb_in;
  logic [DATA_WIDTH-1:0]   abs_a, abs_b;
  logic                    div_zero, div_ovf, special;
  logic [DATA_WIDTH-1:0]   special_res;

  // iteration datapath
  logic [OPCODE_LENGTH-1:0] alu_op;
  logic [DATA_WIDTH-1:0]   alu_a, alu_y;
  logic [DATA_WIDTH-1:0]   rsh;
  logic                    carry, borrow;
  logic [DATA_WIDTH-1:0]   hsum;
  logic [DATA_WIDTH-1:0]   hi_n, lo_n;

  // fix-up datapath
  logic [2*DATA_WIDTH-1:0] prod, prod_fix;
  logic [DATA_WIDTH-1:0]   quo_fix, rem_fix, fix_res;

  assign f3_in  = funct3_e'(funct3_i);
  assign accept = (state == S_IDLE) && start_i && !flush_i;

  always_comb begin
    sa_in = op_a_i[DATA_WIDTH-1] &
            ((f3_in == F3_MULH) || (f3_in == F3_MULHSU) ||
             (f3_in == F3_DIV)  || (f3_in == F3_REM));
    sb_in = op_b_i[DATA_WIDTH-1] &
            ((f3_in == F3_MULH) || (f3_in == F3_DIV) || (f3_in == F3_REM));
    abs_a = sa_in ? (~op_a_i + 1'b1) : op_a_i;
    abs_b = sb_in ? (~op_b_i + 1'b1) : op_b_i;

    div_zero = is_div(f3_in) && (op_b_i == '0);
    div_ovf  = ((f3_in == F3_DIV) || (f3_in == F3_REM)) &&
               (op_a_i == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (op_b_i == '1);
    special  = div_zero || div_ovf;

    // funct3[1] selects the remainder variants within the divide group.
    special_res = '0;
    if (div_zero)
      special_res = funct3_i[1] ? op_a_i : '1;
    else if (div_ovf)
      special_res = funct3_i[1] ? '0 : {1'b1, {(DATA_WIDTH-1){1'b0}}};
  end

  // Shared add/sub engine: ADD for multiply accumulation, SUB for the divide trial.
  always_comb begin
    alu_op = ALU_ADD;
    if (state == S_CALC && is_div(f3))
      alu_op = ALU_SUB;
  end

  assign rsh   = {hi[DATA_WIDTH-2:0], lo[DATA_WIDTH-1]};
  assign alu_a = is_div(f3) ? rsh : hi;

  alu #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OPCODE_LENGTH(OPCODE_LENGTH)
  ) u_alu (
    .operation (alu_op),
    .src_a     (alu_a),
    .src_b     (mb),
    .alu_result(alu_y)
  );

  always_comb begin
    // Carry-out of hi+mb wraps below hi; borrow is the 33-bit compare of
    // {hi[31], rsh} against mb - when the shifted-out bit is set the
    // remainder already exceeds any 32-bit divisor.
    carry  = (alu_y < hi);
    borrow = !hi[DATA_WIDTH-1] && (rsh < mb);
    hsum   = lo[0] ? alu_y : hi;
    hi_n   = hi;
    lo_n   = lo;
    if (is_div(f3)) begin
      if (!borrow) begin
        hi_n = alu_y;
        lo_n = {lo[DATA_WIDTH-2:0], 1'b1};
      end else begin
        hi_n = rsh;
        lo_n = {lo[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n = {lo[0] & carry, hsum[DATA_WIDTH-1:1]};
      lo_n = {hsum[0], lo[DATA_WIDTH-1:1]};
    end
  end

  always_comb begin
    prod     = {hi, lo};
    prod_fix = (sa ^ sb) ? (~prod + 1'b1) : prod;
    quo_fix  = (sa ^ sb) ? (~lo + 1'b1) : lo;
    rem_fix  = sa ? (~hi + 1'b1) : hi;
    fix_res  = '0;
    case (f3)
      F3_MUL:                       fix_res = prod_fix[DATA_WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
      F3_DIV, F3_DIVU:              fix_res = quo_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = special ? S_DONE : S_CALC;
      S_CALC:  if (flush_i) state_n = S_IDLE;
               else if (count == 5'(ITER-1)) state_n = S_FIXUP;
      S_FIXUP: state_n = flush_i ? S_IDLE : S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign busy_o = (state != S_IDLE);
  // A flush arriving in DONE still suppresses the pulse.
  assign done_o = (state == S_DONE) && !flush_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f3       <= F3_MUL;
      sa       <= 1'b0;
      sb       <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      mb       <= '0;
      count    <= '0;
      result_o <= '0;
    end else begin
      if (accept) begin
        f3    <= f3_in;
        sa    <= sa_in;
        sb    <= sb_in;
        hi    <= '0;
        lo    <= abs_a;
        mb    <= abs_b;
        count <= '0;
        if (special)
          result_o <= special_res;
      end else if (state == S_CALC && !flush_i) begin
        hi    <= hi_n;
        lo    <= lo_n;
        count <= count + 5'd1;
      end else if (state == S_FIXUP && !flush_i) begin
        result_o <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  muldiv_ctrl #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_i),
    .flush_i (flush_i),
    .funct3_i(funct3_i),
    .op_a_i  (op_a_i),
    .op_b_i  (op_b_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_res = '0;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done_o pulse pops the oldest expectation.
  always @(negedge clk) begin
    if (!reset && done_o) begin
      check("done_single_pulse", {31'd0, prev_done}, 32'd0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %h expected no done", result_o);
      end else begin
        mon_e = sbq.pop_front();
        check({mon_e.name, "_result"}, result_o, mon_e.res);
        check({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.due));
      end
    end
    prev_done <= done_o;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy 1 expected 0");
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start_i  = 1'b1;
    funct3_i = f;
    op_a_i   = a;
    op_b_i   = b;
  endtask

  task automatic issue(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    exp_t e;
    wait_idle();
    drive(f, a, b);
    e.res  = exp;
    e.due  = cyc + lat;
    e.name = nm;
    sbq.push_back(e);
    last_res = exp;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start_i  = 1'b0;
    flush_i  = 1'b0;
    funct3_i = '0;
    op_a_i   = '0;
    op_b_i   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    reset = 1'b0;

    // Directed vectors; latency counts edges from the drive point.
    issue("mul_7_m3",     3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    issue("mulh_7_m3",    3'b001, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 34);
    issue("mulhu_max",    3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    issue("mulhsu_m1_2",  3'b010, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 34);
    issue("mul_shift",    3'b000, 32'h12345678,   32'h10,       32'h23456780, 34);
    issue("div_m7_2",     3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34);
    issue("rem_m7_2",     3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34);
    issue("divu_100_7",   3'b101, 32'd100,        32'd7,        32'd14,       34);
    issue("remu_100_7",   3'b111, 32'd100,        32'd7,        32'd2,        34);
    issue("divu_big",     3'b101, 32'hFFFFFFFF,   32'h80000001, 32'd1,        34);
    issue("remu_big",     3'b111, 32'hFFFFFFFF,   32'h80000001, 32'h7FFFFFFE, 34);
    issue("div_5_0",      3'b100, 32'd5,          32'd0,        32'hFFFFFFFF, 1);
    issue("rem_5_0",      3'b110, 32'd5,          32'd0,        32'd5,        1);
    issue("div_ovf",      3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1);
    issue("rem_ovf",      3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1);
    drain();

    // start_i held (with changed operands) while busy must be ignored.
    begin
      exp_t e;
      wait_idle();
      drive(3'b000, 32'd7, 32'hFFFFFFFD);
      e.res  = 32'hFFFFFFEB;
      e.due  = cyc + 34;
      e.name = "mul_held_start";
      sbq.push_back(e);
      last_res = e.res;
      @(posedge clk);
      @(negedge clk);
      drive(3'b100, 32'd5, 32'd0);
      repeat (10) @(negedge clk);
      check("held_start_busy", {31'd0, busy_o}, 32'd1);
      start_i = 1'b0;
      drain();
    end

    // Flush at count 10 of DIVU 100/7.
    wait_idle();
    drive(3'b101, 32'd100, 32'd7);
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("flush_busy_before", {31'd0, busy_o}, 32'd1);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    check("flush_busy_after", {31'd0, busy_o}, 32'd0);
    check("flush_result_kept", result_o, last_res);
    flush_i = 1'b0;
    repeat (40) @(negedge clk);
    check("flush_result_still", result_o, last_res);

    // Asynchronous reset mid-CALC.
    wait_idle();
    drive(3'b000, 32'h12345678, 32'd9);
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_busy", {31'd0, busy_o}, 32'd0);
    check("async_reset_done", {31'd0, done_o}, 32'd0);
    check("async_reset_result", result_o, 32'd0);
    last_res = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    issue("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, 34);
    drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
